// File: rtl/xadc_emu_pkg.sv
// Shared definitions for the XADC DRP emulator: register map, sequencer states
// and channel-ordering helpers used by the sequencer.
package xadc_emu_pkg;

    localparam logic [6:0] ADDR_AUX0     = 7'h10;
    localparam logic [6:0] ADDR_AUX1     = 7'h11;
    localparam logic [6:0] ADDR_AUX2     = 7'h12;
    localparam logic [6:0] ADDR_AUX3     = 7'h13;
    localparam logic [6:0] ADDR_CFG0     = 7'h40;
    localparam logic [6:0] ADDR_CFG1     = 7'h41;
    localparam logic [6:0] ADDR_CFG2     = 7'h42;
    localparam logic [6:0] ADDR_SEQCHSEL = 7'h49;

    localparam logic [3:0] MODE_CONTINUOUS = 4'h2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CONV     = 2'd1,
        COMPLETE = 2'd2
    } seq_state_t;

    function automatic logic [1:0] first_channel(input logic [3:0] mask);
        logic [1:0] res;
        res = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) res = 2'(i);
        end
        return res;
    endfunction

    // Lowest enabled channel above cur, wrapping to the lowest enabled one.
    function automatic logic [1:0] next_channel(input logic [3:0] mask, input logic [1:0] cur);
        logic [1:0] res;
        res = first_channel(mask);
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(cur) && mask[i]) res = 2'(i);
        end
        return res;
    endfunction

    function automatic logic last_channel(input logic [3:0] mask, input logic [1:0] cur);
        logic last;
        last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > int'(cur) && mask[i]) last = 1'b0;
        end
        return last;
    endfunction

endpackage

// File: rtl/xadc_drp_emulator_if.sv
// DRP bus between the xadc_interface initiator (master) and the emulator (slave).
interface xadc_drp_emulator_if;

    logic [6:0]  DADDR;
    logic        DEN;
    logic        DWE;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DRDY;

    modport master (
        output DADDR, DEN, DWE, DI,
        input  DO, DRDY
    );

    modport slave (
        input  DADDR, DEN, DWE, DI,
        output DO, DRDY
    );

endinterface

// File: rtl/xadc_emu_drp_port.sv
// DRP responder: accepts one transaction at a time, commits writes in the DEN
// cycle and returns DO/DRDY a fixed DRP_LATENCY clocks later.
module xadc_emu_drp_port
    import xadc_emu_pkg::*;
#(
    parameter int DRP_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    xadc_drp_emulator_if.slave   drp,
    input  logic [15:0]          rd_data,
    output logic                 wr_en,
    output logic [6:0]           wr_addr,
    output logic [15:0]          wr_data
);

    logic        outstanding;
    logic [3:0]  lat_cnt;
    logic [15:0] data_q;
    logic        accept;

    assign accept  = drp.DEN && !outstanding;
    assign wr_en   = accept && drp.DWE;
    assign wr_addr = drp.DADDR;
    assign wr_data = drp.DI;

    // lat_cnt counts down to 1; DRDY is registered on that edge so it lands
    // exactly DRP_LATENCY cycles after the DEN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= 1'b0;
            lat_cnt     <= 4'd0;
            data_q      <= 16'h0000;
            drp.DO      <= 16'h0000;
            drp.DRDY    <= 1'b0;
        end else begin
            drp.DRDY <= 1'b0;
            drp.DO   <= 16'h0000;
            if (accept) begin
                data_q <= drp.DWE ? 16'h0000 : rd_data;
                if (DRP_LATENCY == 1) begin
                    drp.DRDY <= 1'b1;
                    drp.DO   <= drp.DWE ? 16'h0000 : rd_data;
                end else begin
                    outstanding <= 1'b1;
                    lat_cnt     <= 4'(DRP_LATENCY - 1);
                end
            end else if (outstanding) begin
                if (lat_cnt == 4'd1) begin
                    outstanding <= 1'b0;
                    drp.DRDY    <= 1'b1;
                    drp.DO      <= data_q;
                end else begin
                    lat_cnt <= lat_cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/xadc_drp_emulator.sv
// XADC DRP responder stand-in with a continuous aux-channel sequencer.
// Optional result dither is enabled by defining XADC_EMU_DITHER_EN.
//
// state    | meaning
// IDLE     | sequencer stopped or waiting for the enable condition
// CONV     | converting cur_ch, BUSY high, CONV_CYCLES clocks
// COMPLETE | one cycle: EOC/EOS pulse, result register written
module xadc_drp_emulator
    import xadc_emu_pkg::*;
#(
    parameter int          CONV_CYCLES = 26,
    parameter int          DRP_LATENCY = 4,
    parameter logic [15:0] INIT_41     = 16'h20F0,
    parameter logic [15:0] INIT_49     = 16'h000F
) (
    input  logic                 clk,
    input  logic                 rst,
    xadc_drp_emulator_if.slave   drp,
    input  logic [47:0]          aux_value,
    output logic                 BUSY,
    output logic                 EOC,
    output logic                 EOS,
    output logic [4:0]           CHANNEL,
    output logic [4:0]           MUXADDR
);

    localparam logic [7:0] CONV_LOAD = 8'(CONV_CYCLES - 1);

    logic [15:0] cfg40, cfg41, cfg42, cfg49;
    logic [11:0] results [4];
    seq_state_t  state;
    logic [1:0]  cur_ch;
    logic [1:0]  start_ch;
    logic [7:0]  conv_cnt;
    logic [11:0] sample_q;
    logic [11:0] aux_slice;
    logic [11:0] store_val;
    logic [15:0] rd_data;
    logic        wr_en;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        seq_enabled;
    logic        restart;
    logic [3:0]  mask;

    xadc_emu_drp_port #(.DRP_LATENCY(DRP_LATENCY)) u_drp_port (
        .clk     (clk),
        .rst     (rst),
        .drp     (drp),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    assign mask        = cfg49[3:0];
    assign seq_enabled = (cfg41[15:12] == MODE_CONTINUOUS) && (mask != 4'h0);
    assign restart     = wr_en && (wr_addr == ADDR_CFG1 || wr_addr == ADDR_SEQCHSEL);
    assign start_ch    = (state == COMPLETE) ? next_channel(mask, cur_ch) : first_channel(mask);

    // Read data comes from the registers as they stand in the DEN cycle.
    always_comb begin
        rd_data = 16'h0000;
        case (drp.DADDR)
            ADDR_AUX0:     rd_data = {results[0], 4'h0};
            ADDR_AUX1:     rd_data = {results[1], 4'h0};
            ADDR_AUX2:     rd_data = {results[2], 4'h0};
            ADDR_AUX3:     rd_data = {results[3], 4'h0};
            ADDR_CFG0:     rd_data = cfg40;
            ADDR_CFG1:     rd_data = cfg41;
            ADDR_CFG2:     rd_data = cfg42;
            ADDR_SEQCHSEL: rd_data = cfg49;
            default:       rd_data = 16'h0000;
        endcase
    end

    always_comb begin
        aux_slice = aux_value[11:0];
        case (cur_ch)
            2'd0: aux_slice = aux_value[11:0];
            2'd1: aux_slice = aux_value[23:12];
            2'd2: aux_slice = aux_value[35:24];
            2'd3: aux_slice = aux_value[47:36];
            default: aux_slice = aux_value[11:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg40 <= 16'h0000;
            cfg41 <= INIT_41;
            cfg42 <= 16'h0000;
            cfg49 <= INIT_49;
        end else if (wr_en) begin
            case (wr_addr)
                ADDR_CFG0:     cfg40 <= wr_data;
                ADDR_CFG1:     cfg41 <= wr_data;
                ADDR_CFG2:     cfg42 <= wr_data;
                ADDR_SEQCHSEL: cfg49 <= wr_data;
                default:       ;
            endcase
        end
    end

`ifdef XADC_EMU_DITHER_EN
    logic [15:0] lfsr;
    logic [12:0] dither_sum;

    assign dither_sum = {1'b0, sample_q} + {12'h000, lfsr[0]};
    assign store_val  = dither_sum[12] ? 12'hFFF : dither_sum[11:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (state == COMPLETE) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`else
    assign store_val = sample_q;
`endif

    // The result register is written at the end of COMPLETE so a read issued
    // in the COMPLETE cycle still returns the previous sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_ch   <= 2'd0;
            conv_cnt <= 8'd0;
            sample_q <= 12'h000;
            BUSY     <= 1'b0;
            EOC      <= 1'b0;
            EOS      <= 1'b0;
            CHANNEL  <= 5'h00;
            MUXADDR  <= 5'h00;
            for (int i = 0; i < 4; i++) results[i] <= 12'h000;
        end else begin
            EOC <= 1'b0;
            EOS <= 1'b0;
            if (restart) begin
                state <= IDLE;
                BUSY  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (seq_enabled) begin
                            state    <= CONV;
                            cur_ch   <= start_ch;
                            MUXADDR  <= {3'b000, start_ch};
                            conv_cnt <= CONV_LOAD;
                            BUSY     <= 1'b1;
                        end
                    end
                    CONV: begin
                        if (conv_cnt == 8'd0) begin
                            state    <= COMPLETE;
                            BUSY     <= 1'b0;
                            EOC      <= 1'b1;
                            EOS      <= last_channel(mask, cur_ch);
                            CHANNEL  <= {3'b100, cur_ch};
                            sample_q <= aux_slice;
                        end else begin
                            conv_cnt <= conv_cnt - 8'd1;
                        end
                    end
                    COMPLETE: begin
                        results[cur_ch] <= store_val;
                        if (seq_enabled) begin
                            state    <= CONV;
                            cur_ch   <= start_ch;
                            MUXADDR  <= {3'b000, start_ch};
                            conv_cnt <= CONV_LOAD;
                            BUSY     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xadc_drp_emulator.sv
// Self-checking bench for xadc_drp_emulator: DRP register table, sequencer
// timing sequences and randomized reads against a register/result model.
module tb_xadc_drp_emulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] aux_value;
    logic        BUSY, EOC, EOS;
    logic [4:0]  CHANNEL, MUXADDR;

    xadc_drp_emulator_if drp_bus ();

    xadc_drp_emulator #(
        .CONV_CYCLES (26),
        .DRP_LATENCY (4),
        .INIT_41     (16'h20F0),
        .INIT_49     (16'h000F)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .drp       (drp_bus),
        .aux_value (aux_value),
        .BUSY      (BUSY),
        .EOC       (EOC),
        .EOS       (EOS),
        .CHANNEL   (CHANNEL),
        .MUXADDR   (MUXADDR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Model: results become visible the cycle after an observed EOC and hold
    // the aux slice present during the cycle before that EOC.
    logic [11:0] model_res [4];
    logic [15:0] cfg_m [4];
    bit          pend_v;
    logic [1:0]  pend_ch;
    logic [11:0] pend_val;
    logic [47:0] aux_q;
    int          ev_cyc [$];
    logic [4:0]  ev_ch [$];
    logic        ev_eos [$];
    int          busy_runs [$];
    int          busy_run = 0;
    int          busy_total = 0;

    function automatic logic [11:0] slice_of(input logic [47:0] v, input int n);
        return v[n*12 +: 12];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) model_res[i] = 12'h000;
            pend_v = 0;
            busy_run = 0;
        end else begin
            if (pend_v) begin
                model_res[pend_ch] = pend_val;
                pend_v = 0;
            end
            if (EOC) begin
                ev_cyc.push_back(cyc);
                ev_ch.push_back(CHANNEL);
                ev_eos.push_back(EOS);
                pend_v = 1;
                pend_ch = CHANNEL[1:0];
                pend_val = slice_of(aux_q, int'(CHANNEL[1:0]));
            end
            if (BUSY) begin
                busy_run++;
                busy_total++;
            end else if (busy_run != 0) begin
                busy_runs.push_back(busy_run);
                busy_run = 0;
            end
        end
        aux_q = aux_value;
    end

    function automatic logic [15:0] exp_read(input logic [6:0] a);
        logic [11:0] r;
        case (a)
            7'h10, 7'h11, 7'h12, 7'h13: begin
                r = model_res[a[1:0]];
                if (pend_v && pend_ch == a[1:0]) r = pend_val;
                return {r, 4'h0};
            end
            7'h40: return cfg_m[0];
            7'h41: return cfg_m[1];
            7'h42: return cfg_m[2];
            7'h49: return cfg_m[3];
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit read_ok(input logic [6:0] a, input logic [15:0] act, input logic [15:0] exp);
        if (act === exp) return 1;
`ifdef XADC_EMU_DITHER_EN
        if (a >= 7'h10 && a <= 7'h13 && act[3:0] == 4'h0 && exp[15:4] != 12'hFFF &&
            act[15:4] == exp[15:4] + 12'd1) return 1;
`endif
        return 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_rd(input string name, input logic [6:0] a, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (!read_ok(a, act, exp)) begin
            failures++;
            $display("FAIL %s addr=%0h: actual DO=%0h required DO=%0h", name, a, act, exp);
        end
    endtask

    task automatic drp_xact(input logic we, input logic [6:0] a, input logic [15:0] d, input bit now,
                            output logic [15:0] rdata, output int lat, output int nrdy,
                            output int tden, output logic [15:0] exp);
        if (!now) begin
            @(posedge clk);
            #1;
        end
        drp_bus.DEN = 1'b1;
        drp_bus.DWE = we;
        drp_bus.DADDR = a;
        drp_bus.DI = d;
        tden = cyc;
        exp = we ? 16'h0000 : exp_read(a);
        if (we) begin
            case (a)
                7'h40: cfg_m[0] = d;
                7'h41: cfg_m[1] = d;
                7'h42: cfg_m[2] = d;
                7'h49: cfg_m[3] = d;
                default: ;
            endcase
        end
        lat = -1;
        nrdy = 0;
        rdata = 16'h0000;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (drp_bus.DRDY) begin
                nrdy++;
                if (lat < 0) begin
                    lat = k;
                    rdata = drp_bus.DO;
                end
            end
            @(posedge clk);
            #1;
            drp_bus.DEN = 1'b0;
        end
    endtask

    task automatic xact_chk(input string name, input logic we, input logic [6:0] a, input logic [15:0] d, input bit now);
        logic [15:0] rd, ex;
        int lat, nrdy, td;
        drp_xact(we, a, d, now, rd, lat, nrdy, td, ex);
        check({name, "_latency"}, lat, 4);
        check_rd(name, a, rd, ex);
    endtask

    task automatic wait_eoc(input logic [4:0] ch, input int limit);
        bit found = 0;
        for (int i = 0; i < limit && !found; i++) begin
            @(posedge clk);
            #1;
            if (EOC && CHANNEL == ch) found = 1;
        end
        check($sformatf("wait_eoc_ch%0h", ch), found, 1);
    endtask

    task automatic wait_events(input int n, input int limit);
        for (int i = 0; i < limit && ev_cyc.size() < n; i++) @(posedge clk);
        check("event_count", (ev_cyc.size() >= n), 1);
    endtask

    typedef struct {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [14];
        logic [15:0] rd, ex;
        int          lat, nrdy, td, r, w, first_k;
        int          neoc;
        logic [6:0]  ra;
        logic [6:0]  rd_list [10];

        tbl[0]  = '{1'b0, 7'h41, 16'h0000, 16'h20F0};
        tbl[1]  = '{1'b0, 7'h49, 16'h0000, 16'h000F};
        tbl[2]  = '{1'b0, 7'h40, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 7'h42, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b0, 7'h7F, 16'h0000, 16'h0000};
        tbl[5]  = '{1'b0, 7'h00, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b1, 7'h40, 16'h1234, 16'h0000};
        tbl[7]  = '{1'b0, 7'h40, 16'h0000, 16'h1234};
        tbl[8]  = '{1'b1, 7'h42, 16'hABCD, 16'h0000};
        tbl[9]  = '{1'b0, 7'h42, 16'h0000, 16'hABCD};
        tbl[10] = '{1'b1, 7'h7F, 16'hFFFF, 16'h0000};
        tbl[11] = '{1'b0, 7'h7F, 16'h0000, 16'h0000};
        tbl[12] = '{1'b1, 7'h13, 16'hFFFF, 16'h0000};
        tbl[13] = '{1'b0, 7'h4A, 16'h0000, 16'h0000};

        cfg_m[0] = 16'h0000; cfg_m[1] = 16'h20F0; cfg_m[2] = 16'h0000; cfg_m[3] = 16'h000F;
        drp_bus.DEN = 1'b0; drp_bus.DWE = 1'b0; drp_bus.DADDR = 7'h00; drp_bus.DI = 16'h0000;
        aux_value = {12'h400, 12'h300, 12'h200, 12'h100};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_do", drp_bus.DO, 0);
        check("reset_drdy", drp_bus.DRDY, 0);
        check("reset_busy", BUSY, 0);
        check("reset_eoc", EOC, 0);
        check("reset_eos", EOS, 0);
        check("reset_channel", CHANNEL, 0);
        check("reset_muxaddr", MUXADDR, 0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        r = cyc;

        for (int i = 0; i < 14; i++) begin
            drp_xact(tbl[i].we, tbl[i].addr, tbl[i].data, 0, rd, lat, nrdy, td, ex);
            check($sformatf("tbl%0d_latency", i), lat, 4);
            check($sformatf("tbl%0d_drdy_count", i), nrdy, 1);
            check($sformatf("tbl%0d_do", i), rd, tbl[i].exp);
        end

        // Sequencer from reset: 27-cycle EOC spacing, ascending channels, EOS on ch3.
        wait_events(8, 400);
        if (ev_cyc.size() >= 8) begin
            check("first_eoc_cycle", ev_cyc[0] - r, 27);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("seq_channel_%0d", i), ev_ch[i], 5'h10 + 5'(i % 4));
                check($sformatf("seq_eos_%0d", i), ev_eos[i], (i % 4 == 3));
                if (i > 0) check($sformatf("seq_period_%0d", i), ev_cyc[i] - ev_cyc[i-1], 27);
            end
        end
        check("busy_run_count", (busy_runs.size() >= 4), 1);
        for (int i = 0; i < 4 && i < busy_runs.size(); i++)
            check($sformatf("busy_len_%0d", i), busy_runs[i], 26);
        drp_xact(1'b0, 7'h10, 16'h0, 0, rd, lat, nrdy, td, ex);
        check_rd("read_aux0_init", 7'h10, rd, 16'h1000);

        // Second DEN two cycles into an outstanding read is ignored.
        @(posedge clk);
        #1;
        drp_bus.DEN = 1'b1; drp_bus.DWE = 1'b0; drp_bus.DADDR = 7'h49; drp_bus.DI = 16'h0000;
        nrdy = 0; first_k = -1; rd = 16'h0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (drp_bus.DRDY) begin
                nrdy++;
                if (first_k < 0) begin first_k = k; rd = drp_bus.DO; end
            end
            @(posedge clk);
            #1;
            drp_bus.DEN = (k + 1 == 2);
            drp_bus.DWE = 1'b1; drp_bus.DADDR = 7'h40; drp_bus.DI = 16'hBEEF;
        end
        drp_bus.DEN = 1'b0;
        check("overlap_drdy_count", nrdy, 1);
        check("overlap_latency", first_k, 4);
        check("overlap_do", rd, 16'h000F);
        drp_xact(1'b0, 7'h40, 16'h0, 0, rd, lat, nrdy, td, ex);
        check("overlap_write_dropped", rd, 16'h1234);

        // Channel-select write in the middle of a ch1 conversion.
        wait_eoc(5'h10, 200);
        repeat (10) @(posedge clk);
        #1;
        drp_bus.DEN = 1'b1; drp_bus.DWE = 1'b1; drp_bus.DADDR = 7'h49; drp_bus.DI = 16'h0005;
        cfg_m[3] = 16'h0005;
        w = cyc;
        ev_cyc.delete(); ev_ch.delete(); ev_eos.delete();
        @(negedge clk);
        check("busy_before_abort", BUSY, 1);
        @(posedge clk);
        #1;
        drp_bus.DEN = 1'b0;
        @(negedge clk);
        check("busy_after_abort", BUSY, 0);
        wait_events(4, 200);
        if (ev_cyc.size() >= 4) begin
            check("restart_first_eoc", ev_cyc[0] - w, 28);
            check("restart_period", ev_cyc[2] - ev_cyc[0], 54);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("mask5_channel_%0d", i), ev_ch[i], (i % 2 == 0) ? 5'h10 : 5'h12);
                check($sformatf("mask5_eos_%0d", i), ev_eos[i], (i % 2 == 1));
            end
        end

        // Disable by mode field, then re-enable.
        drp_xact(1'b1, 7'h41, 16'h0000, 0, rd, lat, nrdy, td, ex);
        ev_cyc.delete(); ev_ch.delete(); ev_eos.delete();
        busy_total = 0;
        neoc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (EOC || EOS) neoc++;
        end
        check("disabled_eoc_count", neoc, 0);
        check("disabled_busy_cycles", busy_total, 0);
        drp_xact(1'b1, 7'h41, 16'h2000, 0, rd, lat, nrdy, w, ex);
        wait_events(1, 100);
        if (ev_cyc.size() >= 1) begin
            check("reenable_first_eoc", ev_cyc[0] - w, 28);
            check("reenable_channel", ev_ch[0], 5'h10);
        end

        // Read issued in the COMPLETE cycle sees the previous result.
        wait_eoc(5'h12, 200);
        aux_value[11:0] = 12'h200;
        wait_eoc(5'h10, 200);
        drp_xact(1'b0, 7'h10, 16'h0, 1, rd, lat, nrdy, td, ex);
        check_rd("read_in_complete", 7'h10, rd, 16'h1000);
        drp_xact(1'b0, 7'h10, 16'h0, 0, rd, lat, nrdy, td, ex);
        check_rd("read_after_complete", 7'h10, rd, 16'h2000);

        // Full-scale input never exceeds 16'hFFF0.
        wait_eoc(5'h12, 200);
        aux_value[11:0] = 12'hFFF;
        wait_eoc(5'h12, 200);
        wait_eoc(5'h10, 200);
        repeat (2) @(posedge clk);
        drp_xact(1'b0, 7'h10, 16'h0, 0, rd, lat, nrdy, td, ex);
        check("full_scale", rd, 16'hFFF0);

        // Randomized traffic against the model.
        xact_chk("enable_all", 1'b1, 7'h49, 16'h000F, 0);
        rd_list[0] = 7'h10; rd_list[1] = 7'h11; rd_list[2] = 7'h12; rd_list[3] = 7'h13;
        rd_list[4] = 7'h40; rd_list[5] = 7'h41; rd_list[6] = 7'h42; rd_list[7] = 7'h49;
        rd_list[8] = 7'h7F; rd_list[9] = 7'h20;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) aux_value = {$urandom, $urandom};
            repeat ($urandom_range(0, 20)) @(posedge clk);
            if ($urandom_range(0, 4) == 0) begin
                ra = ($urandom_range(0, 1) == 0) ? 7'h40 : 7'h42;
                xact_chk($sformatf("rand_wr%0d", it), 1'b1, ra, 16'($urandom), 0);
            end else begin
                ra = ($urandom_range(0, 5) == 0) ? 7'($urandom) : rd_list[$urandom_range(0, 9)];
                if (ra == 7'h41 || ra == 7'h49) ra = 7'h13;
                xact_chk($sformatf("rand_rd%0d", it), 1'b0, ra, 16'h0, 0);
            end
        end

        // Reset in the middle of a transaction and a conversion.
        wait_eoc(5'h10, 200);
        repeat (5) @(posedge clk);
        #1;
        drp_bus.DEN = 1'b1; drp_bus.DWE = 1'b0; drp_bus.DADDR = 7'h49;
        nrdy = 0; neoc = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k >= 3 && drp_bus.DRDY) nrdy++;
            if (k >= 3 && EOC) neoc++;
            @(posedge clk);
            #1;
            drp_bus.DEN = 1'b0;
            rst = (k + 1 == 2 || k + 1 == 3);
        end
        cfg_m[0] = 16'h0000; cfg_m[1] = 16'h20F0; cfg_m[2] = 16'h0000; cfg_m[3] = 16'h000F;
        check("rst_drdy_cancel", nrdy, 0);
        check("rst_no_eoc", neoc, 0);
        drp_xact(1'b0, 7'h49, 16'h0, 0, rd, lat, nrdy, td, ex);
        check("rst_cfg49", rd, 16'h000F);
        drp_xact(1'b0, 7'h40, 16'h0, 0, rd, lat, nrdy, td, ex);
        check("rst_cfg40", rd, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
